// File: rtl/dice_pkg.sv
// Shared definitions for the electronic die.
//   - FSM state encodings (IDLE, ROLL, SLOW, HOLD)
//   - Value register width
//   - The six LED pip patterns, bit map:
//       [0] top-left  [1] top-right  [2] mid-left  [3] centre
//       [4] mid-right [5] bottom-left [6] bottom-right
//   - next_value(): 1..6 wrap-around successor
package dice_pkg;

    localparam int VALUE_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ROLL = 2'd1;
    localparam state_t ST_SLOW = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    localparam logic [6:0] FACE_1 = 7'b0001000;
    localparam logic [6:0] FACE_2 = 7'b1000001;
    localparam logic [6:0] FACE_3 = 7'b1001001;
    localparam logic [6:0] FACE_4 = 7'b1100011;
    localparam logic [6:0] FACE_5 = 7'b1101011;
    localparam logic [6:0] FACE_6 = 7'b1110111;

    // 6 (or any illegal code) wraps to 1, so 0 and 7 can never be produced.
    function automatic logic [VALUE_W-1:0] next_value(input logic [VALUE_W-1:0] v);
        if (v >= 3'd6 || v == 3'd0) begin
            return 3'd1;
        end
        return v + 3'd1;
    endfunction

endpackage

// File: rtl/dice_if.sv
// Die control/display interface.
//   start : roll request, level-sensitive (master -> slave)
//   led   : 7-bit pip pattern (slave -> master)
interface dice_if;

    logic       start;
    logic [6:0] led;

    modport master (output start, input led);
    modport slave  (input start, output led);

endinterface

// File: rtl/dice_face_decoder.sv
// Combinational value-to-pip decoder.
//   value   : 3-bit die value, 1..6 legal
//   pattern : 7-bit pip pattern, blank for 0 and 7
module dice_face_decoder
    import dice_pkg::*;
(
    input  logic [VALUE_W-1:0] value,
    output logic [6:0]         pattern
);

    always_comb begin
        pattern = 7'b0000000;
        case (value)
            3'd1:    pattern = FACE_1;
            3'd2:    pattern = FACE_2;
            3'd3:    pattern = FACE_3;
            3'd4:    pattern = FACE_4;
            3'd5:    pattern = FACE_5;
            3'd6:    pattern = FACE_6;
            default: pattern = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/dice.sv
// Electronic die with a slow-down phase after the roll button is released.
//   clk      : sole clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : dice_if slave modport (start in, led out)
// Parameters:
//   SLOW_STEPS : advances in the slow-down phase (0..15)
//   SLOW_BASE  : wait unit in cycles; step k waits SLOW_BASE*k cycles (1..15)
module dice
    import dice_pkg::*;
#(
    parameter int unsigned SLOW_STEPS = 4,
    parameter int unsigned SLOW_BASE  = 2
) (
    input  logic   clk,
    input  logic   rst,
    dice_if.slave  bus
);

    localparam logic [3:0] STEPS = 4'(SLOW_STEPS);
    localparam logic [7:0] BASE  = 8'(SLOW_BASE);

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic [3:0]         k_q, k_d;
    logic [7:0]         wait_q, wait_d;

    logic [7:0] target;
    logic       step_done;
    logic [6:0] face;

    // Max product 15*15 = 225 fits in 8 bits, so the counter never wraps.
    assign target    = BASE * {4'd0, k_q};
    assign step_done = (wait_q + 8'd1) == target;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        k_d     = k_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ROLL;
                end
            end
            ST_ROLL: begin
                if (bus.start) begin
                    value_d = next_value(value_q);
                end else if (SLOW_STEPS == 0) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SLOW;
                    k_d     = 4'd1;
                    wait_d  = 8'd0;
                end
            end
            ST_SLOW: begin
                // A new roll request wins over the pending slow-down advance.
                if (bus.start) begin
                    state_d = ST_ROLL;
                    value_d = next_value(value_q);
                    k_d     = 4'd0;
                    wait_d  = 8'd0;
                end else if (step_done) begin
                    value_d = next_value(value_q);
                    wait_d  = 8'd0;
                    if (k_q >= STEPS) begin
                        state_d = ST_HOLD;
                        k_d     = 4'd0;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (bus.start) begin
                    state_d = ST_ROLL;
                    value_d = next_value(value_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                value_d = 3'd1;
                k_d     = 4'd0;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            value_q <= 3'd1;
            k_q     <= 4'd0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
        end
    end

    dice_face_decoder u_face (
        .value   (value_q),
        .pattern (face)
    );

    // Display is blank while idle, otherwise shows the current value.
    assign bus.led = (state_q == ST_IDLE) ? 7'b0000000 : face;

endmodule

// File: tb/tb_dice.sv
// Directed self-checking bench for dice (default parameters).
module tb_dice;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dice_if bus ();

    dice #(
        .SLOW_STEPS (4),
        .SLOW_BASE  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int val;

    function automatic logic [6:0] face(input int v);
        case (v)
            1:       return 7'b0001000;
            2:       return 7'b1000001;
            3:       return 7'b1001001;
            4:       return 7'b1100011;
            5:       return 7'b1101011;
            6:       return 7'b1110111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        tests++;
        assert (bus.led === exp)
        else begin
            fails++;
            $error("FAIL %s: led=%b expected=%b", tag, bus.led, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;

        // Reset is asynchronous: blank before any clock edge.
        #2;
        check("reset_async", 7'b0000000);
        step();
        check("reset_held", 7'b0000000);
        rst = 1'b0;

        // Idle with START low stays blank.
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_start0", 7'b0000000);
        end

        // First edge only enters ROLL, then the value advances.
        bus.start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("start_3edges", face(i));
        end

        // Reset held high overrides START; blanking is immediate.
        rst = 1'b1;
        #1;
        check("rst_mid_roll", 7'b0000000);
        step();
        check("rst_over_start_a", 7'b0000000);
        step();
        check("rst_over_start_b", 7'b0000000);
        rst = 1'b0;

        // START held 14 edges from IDLE: 1,2,3,4,5,6,1,2,...,2.
        for (int n = 1; n <= 14; n++) begin
            step();
            check("roll_seq", face(((n - 1) % 6) + 1));
        end
        step();
        check("roll_to_3", face(3));

        // Release at value 3: waits of 2,4,6,8 cycles then HOLD on 1.
        bus.start = 1'b0;
        step();
        check("release_hold_3", face(3));
        val = 3;
        for (int k = 1; k <= 4; k++) begin
            for (int c = 1; c <= 2 * k; c++) begin
                step();
                if (c == 2 * k) val = (val % 6) + 1;
                check("slowdown", face(val));
            end
        end
        check("slow_end_is_1", face(1));
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_stable", face(1));
        end

        // HOLD -> ROLL advances on the same edge.
        bus.start = 1'b1;
        step();
        check("hold_to_roll", face(2));
        bus.start = 1'b0;
        step();
        check("slow2_enter", face(2));
        step();
        check("slow2_k1_wait", face(2));
        step();
        check("slow2_k1_adv", face(3));
        step();
        check("slow2_k2_c1", face(3));
        step();
        check("slow2_k2_c2", face(3));
        // START on the 3rd cycle of k=2 aborts and advances immediately.
        bus.start = 1'b1;
        step();
        check("abort_adv", face(4));
        // Fresh slow-down starts again at k=1 (2-cycle wait).
        bus.start = 1'b0;
        step();
        check("reslow_enter", face(4));
        step();
        check("reslow_wait", face(4));
        step();
        check("reslow_adv_k1", face(5));
        step();
        check("reslow_k2_c1", face(5));

        // Asynchronous reset pulse between edges, mid-SLOW.
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_slow", 7'b0000000);
        rst = 1'b0;
        step();
        check("idle_after_rst", 7'b0000000);
        bus.start = 1'b1;
        step();
        check("roll_after_rst", face(1));
        step();
        check("roll_after_rst_2", face(2));
        bus.start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
